// File: rtl/aib_adapt_ctrl_pkg.sv
// aib_adapt_ctrl_pkg
//   Shared types and helpers for the AIB RX pointer-offset training controller.
//   - state_t    : training FSM state encoding
//   - OFFSETS    : number of read-pointer init offsets swept
//   - win_center : centre of the widest circular run of passing offsets
package aib_adapt_ctrl_pkg;

  localparam int OFFSETS = 8;

  typedef enum logic [3:0] {
    IDLE,
    TRST,
    SETTLE,
    CHECK,
    NEXT,
    SELECT,
    ARST,
    ASETTLE,
    DONE,
    FAIL
  } state_t;

  // Longest circular run of 1s; ties resolve to the lowest start index.
  // An all-ones mask is start 0, length 8. Caller guarantees mask != 0.
  function automatic logic [2:0] win_center(input logic [7:0] mask);
    logic [3:0] best_len;
    logic [3:0] len;
    logic [2:0] best_start;
    logic       run;
    best_len   = 4'd0;
    best_start = 3'd0;
    if (mask == 8'hFF) begin
      best_len = 4'd8;
    end else begin
      for (int s = 0; s < OFFSETS; s++) begin
        // only positions whose circular predecessor is 0 begin a run
        if (mask[s] && !mask[(s + OFFSETS - 1) % OFFSETS]) begin
          len = 4'd0;
          run = 1'b1;
          for (int k = 0; k < OFFSETS; k++) begin
            if (run && mask[(s + k) % OFFSETS]) len = len + 4'd1;
            else run = 1'b0;
          end
          if (len > best_len) begin
            best_len   = len;
            best_start = 3'(s);
          end
        end
      end
    end
    return best_start + 3'((best_len - 4'd1) >> 1);
  endfunction

endpackage

// File: rtl/aib_adapt_ctrl_chk.sv
// aib_adapt_chk
//   Training-pattern checker: data0 is an incrementing 20-bit counter and
//   data1 its bitwise complement. The error flag is registered, so it
//   reports on the word presented one cycle earlier.
//   Ports:
//     i_clk, i_rst        clock, synchronous active-high reset
//     i_en                check this cycle's word
//     i_first             first word of a run: only capture data0, check data1
//     i_data0, i_data1    received words
//     o_err               registered word-error flag (0 when not enabled)
module aib_adapt_chk (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic        i_first,
  input  logic [19:0] i_data0,
  input  logic [19:0] i_data1,
  output logic        o_err
);

  logic [19:0] r_prev;
  logic        r_err;
  logic        w_err;

  assign w_err = (i_data1 != ~i_data0) |
                 (~i_first & (i_data0 != r_prev + 20'd1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev <= 20'd0;
      r_err  <= 1'b0;
    end else begin
      r_err <= i_en & w_err;
      if (i_en) r_prev <= i_data0;
    end
  end

  assign o_err = r_err;

endmodule

// File: rtl/aib_adapt_ctrl.sv
// aib_adapt_ctrl
//   RX pointer-offset training controller for the AIB adapter (RX read-clock
//   domain). Sweeps c_rx_rptr_init over all 8 offsets with the adapter held
//   in reset between trials, checks the training stream per offset, then
//   re-releases the adapter at the centre of the widest passing window.
//   Optional macro AIB_ADAPT_CTRL_RECHECK_EN: keep checking in DONE and
//   raise a sticky o_lock_lost on any word error.
//   Ports:
//     i_clk, i_rst            clock, synchronous active-high reset
//     i_start                 start pulse (ignored while busy)
//     i_rx_data0/1            adapter received data
//     o_rx_rst_n              adapter RX reset (active low)
//     o_rx_wptr_init          constant 0
//     o_rx_rptr_init          trial / selected read-pointer offset
//     o_busy, o_done, o_fail  status
//     o_pass_mask             bit k = offset k passed
//     o_lock_lost             sticky post-training error (0 if feature off)
module aib_adapt_ctrl
  import aib_adapt_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter int CHECK_CYCLES  = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [19:0] i_rx_data0,
  input  logic [19:0] i_rx_data1,
  output logic        o_rx_rst_n,
  output logic [2:0]  o_rx_wptr_init,
  output logic [2:0]  o_rx_rptr_init,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_fail,
  output logic [7:0]  o_pass_mask,
  output logic        o_lock_lost
);

  localparam int MAX_A = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int MAX_P = (MAX_A > CHECK_CYCLES) ? MAX_A : CHECK_CYCLES;
  localparam int CW    = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] RST_LOAD    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CHECK_LOAD  = CW'(CHECK_CYCLES - 1);
  // DONE loads 1 so its first cycle is recognisable for the re-check
  localparam logic [CW-1:0] DONE_LOAD   = CW'(1);

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_load;
  logic          w_tc;
  logic [2:0]    r_trial, r_sel, w_rptr;
  logic [7:0]    r_mask;
  logic          r_pass;
  logic          w_chk_en, w_chk_first, w_err;
  logic          w_rx_rst_n, w_busy, w_done, w_fail, w_start_ok;

  assign w_tc       = (r_cnt == '0);
  assign w_start_ok = i_start & ~w_busy;

  always_comb begin
    w_state_nxt = r_state;
    w_rx_rst_n  = 1'b0;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    w_fail      = 1'b0;
    w_rptr      = r_trial;
    w_chk_en    = 1'b0;
    w_chk_first = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        w_rptr = 3'd0;
        if (i_start) w_state_nxt = TRST;
      end
      TRST: if (w_tc) w_state_nxt = SETTLE;
      SETTLE: begin
        w_rx_rst_n = 1'b1;
        if (w_tc) w_state_nxt = CHECK;
      end
      CHECK: begin
        w_rx_rst_n  = 1'b1;
        w_chk_en    = 1'b1;
        w_chk_first = (r_cnt == CHECK_LOAD);
        if (w_tc) w_state_nxt = NEXT;
      end
      NEXT: begin
        w_rx_rst_n  = 1'b1;
        w_state_nxt = (r_trial == 3'd7) ? SELECT : TRST;
      end
      SELECT: w_state_nxt = (r_mask == 8'd0) ? FAIL : ARST;
      ARST: begin
        w_rptr = r_sel;
        if (w_tc) w_state_nxt = ASETTLE;
      end
      ASETTLE: begin
        w_rptr     = r_sel;
        w_rx_rst_n = 1'b1;
        if (w_tc) w_state_nxt = DONE;
      end
      DONE: begin
        w_busy     = 1'b0;
        w_done     = 1'b1;
        w_rx_rst_n = 1'b1;
        w_rptr     = r_sel;
`ifdef AIB_ADAPT_CTRL_RECHECK_EN
        w_chk_en    = 1'b1;
        w_chk_first = (r_cnt == DONE_LOAD);
`endif
        if (i_start) w_state_nxt = TRST;
      end
      FAIL: begin
        w_busy = 1'b0;
        w_fail = 1'b1;
        w_rptr = 3'd0;
        if (i_start) w_state_nxt = TRST;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_load = '0;
    case (w_state_nxt)
      TRST, ARST:      w_load = RST_LOAD;
      SETTLE, ASETTLE: w_load = SETTLE_LOAD;
      CHECK:           w_load = CHECK_LOAD;
      DONE:            w_load = DONE_LOAD;
      default:         w_load = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_trial <= 3'd0;
      r_sel   <= 3'd0;
      r_mask  <= 8'd0;
      r_pass  <= 1'b0;
    end else begin
      if (w_state_nxt != r_state) r_cnt <= w_load;
      else if (!w_tc)             r_cnt <= r_cnt - CW'(1);

      if (w_start_ok) begin
        r_mask  <= 8'd0;
        r_trial <= 3'd0;
      end

      if (r_state == SETTLE)              r_pass <= 1'b1;
      else if (r_state == CHECK && w_err) r_pass <= 1'b0;

      // checker flag lags one cycle: the last CHECK word is judged here
      if (r_state == NEXT) begin
        r_mask[r_trial] <= r_pass & ~w_err;
        if (r_trial != 3'd7) r_trial <= r_trial + 3'd1;
      end

      if (r_state == SELECT) r_sel <= win_center(r_mask);
    end
  end

  aib_adapt_chk u_chk (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (w_chk_en),
    .i_first (w_chk_first),
    .i_data0 (i_rx_data0),
    .i_data1 (i_rx_data1),
    .o_err   (w_err)
  );

`ifdef AIB_ADAPT_CTRL_RECHECK_EN
  logic r_lock_lost;
  always_ff @(posedge i_clk) begin
    if (i_rst)                       r_lock_lost <= 1'b0;
    else if (w_start_ok)             r_lock_lost <= 1'b0;
    else if (r_state == DONE && w_err) r_lock_lost <= 1'b1;
  end
  assign o_lock_lost = r_lock_lost;
`else
  assign o_lock_lost = 1'b0;
`endif

  assign o_rx_rst_n     = w_rx_rst_n;
  assign o_rx_wptr_init = 3'd0;
  assign o_rx_rptr_init = w_rptr;
  assign o_busy         = w_busy;
  assign o_done         = w_done;
  assign o_fail         = w_fail;
  assign o_pass_mask    = r_mask;

endmodule

// File: tb/tb_aib_adapt_ctrl.sv
// tb_aib_adapt_ctrl
//   Scoreboarded bench for aib_adapt_ctrl. A link model drives a clean
//   training stream for offsets enabled in link_ok and a corrupted one
//   (data1 == data0) otherwise. Each training run pushes its expected
//   result; a monitor pops and compares when o_done or o_fail rises.
//   Also covers the AIB_ADAPT_CTRL_RECHECK_EN build when that macro is set.
module tb_aib_adapt_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [19:0] d0, d1;
  logic        rx_rst_n, busy, done, fail, lock_lost;
  logic [2:0]  wptr, rptr;
  logic [7:0]  mask;

  always #5 clk = ~clk;

  aib_adapt_ctrl dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_rx_data0     (d0),
    .i_rx_data1     (d1),
    .o_rx_rst_n     (rx_rst_n),
    .o_rx_wptr_init (wptr),
    .o_rx_rptr_init (rptr),
    .o_busy         (busy),
    .o_done         (done),
    .o_fail         (fail),
    .o_pass_mask    (mask),
    .o_lock_lost    (lock_lost)
  );

  typedef struct {
    logic [7:0] mask;
    logic [2:0] rptr;
    logic       chk_rptr;
    logic       done;
    logic       fail;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // link model
  logic [7:0]  link_ok;
  int          skip_req = 0;
  int          skip_seen = 0;
  logic [19:0] cnt = 20'd0;
  initial begin
    d0 = 20'd0;
    d1 = ~20'd0;
    forever begin
      @(negedge clk);
      if (skip_req != skip_seen) cnt = cnt + 20'd2;
      else                       cnt = cnt + 20'd1;
      skip_seen = skip_req;
      d0 = cnt;
      d1 = link_ok[rptr] ? ~cnt : cnt;
    end
  end

  // monitor
  logic term_prev = 1'b0;
  exp_t e;
  initial begin
    forever begin
      @(negedge clk);
      if ((done | fail) && !term_prev) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL scoreboard: completion with empty queue, done=%0b fail=%0b", done, fail);
        end else begin
          e = exp_q.pop_front();
          check("pass_mask", mask, e.mask);
          if (e.chk_rptr) check("rptr_sel", rptr, e.rptr);
          check("done", done, e.done);
          check("fail", fail, e.fail);
          check("rx_rst_n_end", rx_rst_n, e.done);
          check("busy_end", busy, 0);
        end
      end
      term_prev = done | fail;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(output int cyc);
    cyc = 0;
    while (!(done | fail) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 3000) begin
      n_checks++;
      $display("FAIL timeout: no done/fail after %0d cycles", cyc);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_rst_n"}, rx_rst_n, 0);
    check({tag, "_rptr"}, rptr, 0);
    check({tag, "_wptr"}, wptr, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_fail"}, fail, 0);
    check({tag, "_mask"}, mask, 0);
    check({tag, "_lock_lost"}, lock_lost, 0);
  endtask

  // success: 8*89 + SELECT + 8 + 16 = 737 cycles; fail: 8*89 + SELECT = 713
  task automatic run(input logic [7:0] ok, input logic [7:0] exp_mask,
                     input logic [2:0] exp_rptr, input logic exp_done);
    int   cyc;
    exp_t x;
    link_ok = ok;
    x.mask = exp_mask; x.rptr = exp_rptr; x.chk_rptr = exp_done;
    x.done = exp_done; x.fail = ~exp_done;
    exp_q.push_back(x);
    pulse_start();
    check("busy_after_start", busy, 1);
    check("lock_lost_after_start", lock_lost, 0);
    check("first_trial_rptr", rptr, 0);
    wait_end(cyc);
    check("sweep_cycles", cyc, exp_done ? 737 : 713);
    tick(2);
  endtask

  initial begin
    int cyc;
    exp_t x;
    rst = 1'b1;
    start = 1'b0;
    link_ok = 8'hFF;
    tick(3);
    rst = 1'b0;
    tick(1);
    check_reset_vals("reset");

    // window 2..5 -> centre 3
    run(8'h3C, 8'h3C, 3'd3, 1'b1);

`ifdef AIB_ADAPT_CTRL_RECHECK_EN
    tick(10);
    check("lock_clean_done", lock_lost, 0);
    skip_req++;
    tick(5);
    check("lock_lost_set", lock_lost, 1);
    tick(20);
    check("lock_lost_sticky", lock_lost, 1);
    check("done_held", done, 1);
`else
    skip_req++;
    tick(10);
    check("lock_lost_tied", lock_lost, 0);
`endif

    // wrap-around window 6,7,0 -> centre 7
    run(8'hC1, 8'hC1, 3'd7, 1'b1);

    // everything corrupt
    run(8'h00, 8'h00, 3'd0, 1'b0);
    check("fail_rx_rst_n", rx_rst_n, 0);

    // all pass, with an ignored second start during the sweep
    link_ok = 8'hFF;
    x.mask = 8'hFF; x.rptr = 3'd3; x.chk_rptr = 1'b1; x.done = 1'b1; x.fail = 1'b0;
    exp_q.push_back(x);
    pulse_start();
    tick(300);
    pulse_start();
    check("ignored_start_rptr", rptr, 3);
    check("ignored_start_busy", busy, 1);
    wait_end(cyc);
    check("ignored_start_cycles", 301 + cyc, 737);
    tick(2);

    // abort during CHECK of trial 4
    pulse_start();
    cyc = 0;
    while (!(rptr == 3'd4 && rx_rst_n) && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    check("reached_trial4", (rptr == 3'd4 && rx_rst_n), 1);
    tick(25);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("abort");
    tick(5);
    check("abort_hold_rx_rst_n", rx_rst_n, 0);
    check("abort_hold_busy", busy, 0);

    // full sweep after abort
    run(8'hFF, 8'hFF, 3'd3, 1'b1);

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
